power_spectrum_unit: RTL and testbench
======================================

POWER_SPECTRUM_UNIT -- requirements
Module: power_spectrum_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of 2, >=4).
REQ-002 SHALL have parameter IDX_WIDTH, default 12, bin index width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_clear  input  1  synchronous flush, active-high.
REQ-006 SHALL have port i_bin_valid  input  1  bin present.
REQ-007 SHALL have port i_bin_data  input  32  [31:16] real, [15:0] imag, signed two's complement.
REQ-008 SHALL have port i_bin_index  input  IDX_WIDTH  bin number k.
REQ-009 SHALL have port i_bin_last  input  1  final bin of frame.
REQ-010 SHALL have port o_bin_ready  output  1  bin accepted when valid & ready.
REQ-011 SHALL have port o_pwr_valid  output  1  FIFO head valid.
REQ-012 SHALL have port i_pwr_ready  input  1  consumer pops head when valid & ready.
REQ-013 SHALL have port o_pwr_data  output  32  unsigned re^2+im^2.
REQ-014 SHALL have port o_pwr_index  output  IDX_WIDTH  bin index of head.
REQ-015 SHALL have port o_pwr_last  output  1  last flag of head.
REQ-016 SHALL have port o_peak_valid  output  1  peak of completed frame available.
REQ-017 SHALL have port o_peak_index  output  IDX_WIDTH  index of maximum-power bin.
REQ-018 SHALL have port o_peak_value  output  32  maximum power.

Function
REQ-019 Pipeline SHALL be S1 (registered re^2, im^2, index, last, valid) -> S2 (registered sum) -> FIFO write; accepted bin at edge E is in S1 at E, S2 at E+1, FIFO at E+2, o_pwr_valid high from E+2.
REQ-020 Squares SHALL be full-precision 32-bit; sum SHALL be 32-bit unsigned without saturation (max 0x8000_0000).
REQ-021 o_bin_ready SHALL be registered-state only: (fifo_count + S1.valid + S2.valid) < FIFO_DEPTH; same-cycle pop not credited.
REQ-022 FIFO SHALL be first-word-fall-through; o_pwr_* driven from head; order preserved; no entry dropped or duplicated.
REQ-023 Simultaneous FIFO write and pop SHALL keep count unchanged; pop when empty SHALL be ignored.
REQ-024 Peak FSM states IDLE, ACTIVE, DONE; evaluation on each S2->FIFO write.
REQ-025 IDLE or DONE + write: peak_value/index loaded with that bin, o_peak_valid<=0, go ACTIVE (or DONE if last).
REQ-026 ACTIVE + write: update peak only if power strictly greater (ties keep earlier bin); last -> DONE, o_peak_valid<=1 at same edge.
REQ-027 DONE SHALL hold o_peak_* stable until next frame's first write or i_clear.
REQ-028 i_clear SHALL have priority over all: S1/S2 invalidated, FIFO emptied, FSM IDLE, peak outputs 0; o_bin_ready SHALL be 0 in the i_clear cycle.
REQ-029 Inputs with i_bin_valid=0 SHALL not alter any state; i_bin_data SHALL be ignored unless accepted.

Reset
REQ-030 nrst=0 at a rising edge SHALL behave as i_clear and take precedence over it.
REQ-031 After reset: o_pwr_valid=0, o_pwr_data=0, o_pwr_index=0, o_pwr_last=0, o_peak_valid=0, o_peak_index=0, o_peak_value=0, FSM IDLE; o_bin_ready=1 in first cycle with nrst=1.
REQ-032 Reset mid-frame SHALL discard all in-flight and buffered bins.

Verification
REQ-033 Reset: hold nrst=0 two edges -> all outputs 0, o_bin_ready=1 next cycle.
REQ-034 Single bin re=0x4000, im=0xC000, index=5, last=1, i_pwr_ready=1 -> o_pwr_data=0x2000_0000, index 5, last 1, valid at E+2; peak_valid=1, peak 0x2000_0000 @5.
REQ-035 Extreme re=0x8000, im=0x8000 -> o_pwr_data=0x8000_0000.
REQ-036 Backpressure: i_pwr_ready=0, stream 10 bins -> exactly 8 accepted, o_bin_ready=0 after; release -> 8 outputs in input order, then remaining 2.
REQ-037 Peak: frame (1,2),(3,0),(0,-3),(1,-1) idx 0..3 -> powers 5,9,9,2; peak_index=1, peak_value=9, peak_valid after last written.
REQ-038 i_clear with 3 bins in flight -> o_pwr_valid=0 and o_peak_valid=0 next cycle, no stale output afterwards.

Source files
------------

// File: rtl/power_spectrum_unit.sv
// Streaming power-spectrum stage: |X[k]|^2 through a two-stage pipeline into a
// first-word-fall-through FIFO, with per-frame peak tracking on FIFO writes.
module power_spectrum_unit #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IDX_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 i_clear,
  input  logic                 i_bin_valid,
  input  logic [31:0]          i_bin_data,
  input  logic [IDX_WIDTH-1:0] i_bin_index,
  input  logic                 i_bin_last,
  output logic                 o_bin_ready,
  output logic                 o_pwr_valid,
  input  logic                 i_pwr_ready,
  output logic [31:0]          o_pwr_data,
  output logic [IDX_WIDTH-1:0] o_pwr_index,
  output logic                 o_pwr_last,
  output logic                 o_peak_valid,
  output logic [IDX_WIDTH-1:0] o_peak_index,
  output logic [31:0]          o_peak_value
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StActive, StDone} peak_state_e;

  logic                 flush;
  logic                 accept;
  logic                 fifo_wr;
  logic                 fifo_rd;
  logic [OccW-1:0]      occupancy;
  logic signed [31:0]   re_ext;
  logic signed [31:0]   im_ext;
  logic signed [31:0]   re_sq;
  logic signed [31:0]   im_sq;

  logic                 s1_valid_q;
  logic [31:0]          s1_re_sq_q;
  logic [31:0]          s1_im_sq_q;
  logic [IDX_WIDTH-1:0] s1_index_q;
  logic                 s1_last_q;

  logic                 s2_valid_q;
  logic [31:0]          s2_sum_q;
  logic [IDX_WIDTH-1:0] s2_index_q;
  logic                 s2_last_q;

  logic [31:0]          mem_data  [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0] mem_index [FIFO_DEPTH];
  logic                 mem_last  [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;

  peak_state_e          peak_state_q;
  logic                 peak_valid_q;
  logic [IDX_WIDTH-1:0] peak_index_q;
  logic [31:0]          peak_value_q;

  assign flush = !nrst || i_clear;

  // Credit counts every bin already committed downstream, so the FIFO can never overflow.
  assign occupancy   = OccW'(count_q) + OccW'(s1_valid_q) + OccW'(s2_valid_q);
  assign o_bin_ready = !flush && (occupancy < DepthOcc);
  assign accept      = i_bin_valid && o_bin_ready;

  assign re_ext = {{16{i_bin_data[31]}}, i_bin_data[31:16]};
  assign im_ext = {{16{i_bin_data[15]}}, i_bin_data[15:0]};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_ff @(posedge clk) begin
    if (flush) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_re_sq_q <= re_sq;
        s1_im_sq_q <= im_sq;
        s1_index_q <= i_bin_index;
        s1_last_q  <= i_bin_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q   <= s1_re_sq_q + s1_im_sq_q;
        s2_index_q <= s1_index_q;
        s2_last_q  <= s1_last_q;
      end
    end
  end

  assign fifo_wr     = s2_valid_q && !flush;
  assign o_pwr_valid = (count_q != '0);
  assign fifo_rd     = o_pwr_valid && i_pwr_ready && !flush;

  // Head is masked so an empty FIFO presents zeros rather than stale storage.
  assign o_pwr_data  = o_pwr_valid ? mem_data[rd_ptr_q]  : '0;
  assign o_pwr_index = o_pwr_valid ? mem_index[rd_ptr_q] : '0;
  assign o_pwr_last  = o_pwr_valid ? mem_last[rd_ptr_q]  : 1'b0;

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr_q]  <= s2_sum_q;
      mem_index[wr_ptr_q] <= s2_index_q;
      mem_last[wr_ptr_q]  <= s2_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({fifo_wr, fifo_rd})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      peak_state_q <= StIdle;
      peak_valid_q <= 1'b0;
      peak_index_q <= '0;
      peak_value_q <= '0;
    end else if (fifo_wr) begin
      unique case (peak_state_q)
        StIdle, StDone: begin
          // First bin of a new frame seeds the running maximum.
          peak_value_q <= s2_sum_q;
          peak_index_q <= s2_index_q;
          peak_valid_q <= s2_last_q;
          peak_state_q <= s2_last_q ? StDone : StActive;
        end
        StActive: begin
          if (s2_sum_q > peak_value_q) begin
            peak_value_q <= s2_sum_q;
            peak_index_q <= s2_index_q;
          end
          if (s2_last_q) begin
            peak_valid_q <= 1'b1;
            peak_state_q <= StDone;
          end
        end
        default: peak_state_q <= StIdle;
      endcase
    end
  end

  assign o_peak_valid = peak_valid_q;
  assign o_peak_index = peak_index_q;
  assign o_peak_value = peak_value_q;

endmodule

// File: tb/tb_power_spectrum_unit.sv
// Scoreboard bench for power_spectrum_unit: directed corner cases plus randomized traffic
// checked against a frame-level reference model.
module tb_power_spectrum_unit;

  localparam int IdxW = 12;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            i_clear = 1'b0;
  logic            i_bin_valid = 1'b0;
  logic [31:0]     i_bin_data = '0;
  logic [IdxW-1:0] i_bin_index = '0;
  logic            i_bin_last = 1'b0;
  logic            o_bin_ready;
  logic            o_pwr_valid;
  logic            i_pwr_ready = 1'b0;
  logic [31:0]     o_pwr_data;
  logic [IdxW-1:0] o_pwr_index;
  logic            o_pwr_last;
  logic            o_peak_valid;
  logic [IdxW-1:0] o_peak_index;
  logic [31:0]     o_peak_value;

  power_spectrum_unit #(.FIFO_DEPTH(8), .IDX_WIDTH(IdxW)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_clear      (i_clear),
    .i_bin_valid  (i_bin_valid),
    .i_bin_data   (i_bin_data),
    .i_bin_index  (i_bin_index),
    .i_bin_last   (i_bin_last),
    .o_bin_ready  (o_bin_ready),
    .o_pwr_valid  (o_pwr_valid),
    .i_pwr_ready  (i_pwr_ready),
    .o_pwr_data   (o_pwr_data),
    .o_pwr_index  (o_pwr_index),
    .o_pwr_last   (o_pwr_last),
    .o_peak_valid (o_peak_valid),
    .o_peak_index (o_peak_index),
    .o_peak_value (o_peak_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] p; logic [IdxW-1:0] idx; logic last;} pwr_t;
  typedef struct packed {int due; logic valid; logic [IdxW-1:0] idx; logic [31:0] val;} pk_t;

  pwr_t            exp_q[$];
  pk_t             pk_q[$];
  logic [31:0]     fr_p[$];
  logic [IdxW-1:0] fr_i[$];
  bit              in_frame = 1'b0;
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_power(input logic [31:0] d);
    longint re, im;
    re = longint'($signed(d[31:16]));
    im = longint'($signed(d[15:0]));
    return 32'(re * re + im * im);
  endfunction

  function automatic logic [31:0] pack(input int re, input int im);
    logic [31:0] r;
    r[31:16] = re[15:0];
    r[15:0]  = im[15:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side of the scoreboard: a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    logic [31:0] p;
    int best;
    if (!nrst || i_clear) begin
      exp_q.delete();
      pk_q.delete();
      fr_p.delete();
      fr_i.delete();
      in_frame = 1'b0;
    end else if (i_bin_valid && o_bin_ready) begin
      p = model_power(i_bin_data);
      exp_q.push_back('{p: p, idx: i_bin_index, last: i_bin_last});
      if (!in_frame) begin
        fr_p.delete();
        fr_i.delete();
      end
      fr_p.push_back(p);
      fr_i.push_back(i_bin_index);
      if (i_bin_last) begin
        best = 0;
        for (int i = 1; i < fr_p.size(); i++) if (fr_p[i] > fr_p[best]) best = i;
        pk_q.push_back('{due: cyc + 3, valid: 1'b1, idx: fr_i[best], val: fr_p[best]});
        in_frame = 1'b0;
      end else begin
        if (!in_frame) pk_q.push_back('{due: cyc + 3, valid: 1'b0, idx: '0, val: '0});
        in_frame = 1'b1;
      end
    end
  end

  // Monitor side: compare the FIFO head on each pop and the peak outputs when due.
  always @(negedge clk) begin
    pwr_t e;
    pk_t pe;
    if (nrst && !i_clear) begin
      if (o_pwr_valid && i_pwr_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_pwr_valid", 64'(o_pwr_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("pwr_data", 64'(o_pwr_data), 64'(e.p));
          check("pwr_index", 64'(o_pwr_index), 64'(e.idx));
          check("pwr_last", 64'(o_pwr_last), 64'(e.last));
        end
      end
      if (pk_q.size() > 0 && pk_q[0].due == cyc) begin
        pe = pk_q.pop_front();
        check("peak_valid", 64'(o_peak_valid), 64'(pe.valid));
        if (pe.valid) begin
          check("peak_value", 64'(o_peak_value), 64'(pe.val));
          check("peak_index", 64'(o_peak_index), 64'(pe.idx));
        end
      end
    end
  end

  task automatic drive_bin(input logic [31:0] d, input int idx, input logic last);
    i_bin_valid = 1'b1;
    i_bin_data  = d;
    i_bin_index = IdxW'(idx);
    i_bin_last  = last;
  endtask

  task automatic idle_bin();
    i_bin_valid = 1'b0;
    i_bin_data  = $urandom;
    i_bin_last  = 1'b0;
  endtask

  initial begin
    int nacc;
    logic acc;
    int mode;

    // Reset held across two edges.
    nrst = 1'b0;
    tick();
    tick();
    check("rst_pwr_valid", 64'(o_pwr_valid), 0);
    check("rst_pwr_data", 64'(o_pwr_data), 0);
    check("rst_pwr_index", 64'(o_pwr_index), 0);
    check("rst_pwr_last", 64'(o_pwr_last), 0);
    check("rst_peak_valid", 64'(o_peak_valid), 0);
    check("rst_peak_index", 64'(o_peak_index), 0);
    check("rst_peak_value", 64'(o_peak_value), 0);
    nrst = 1'b1;
    #1;
    check("rst_bin_ready", 64'(o_bin_ready), 1);

    // Single bin: latency and value.
    i_pwr_ready = 1'b1;
    drive_bin(32'h4000_C000, 5, 1'b1);
    tick();
    idle_bin();
    check("lat_e0_valid", 64'(o_pwr_valid), 0);
    tick();
    check("lat_e1_valid", 64'(o_pwr_valid), 0);
    tick();
    check("lat_e2_valid", 64'(o_pwr_valid), 1);
    check("single_data", 64'(o_pwr_data), 64'h2000_0000);
    check("single_index", 64'(o_pwr_index), 5);
    check("single_last", 64'(o_pwr_last), 1);
    check("single_peak_valid", 64'(o_peak_valid), 1);
    check("single_peak_value", 64'(o_peak_value), 64'h2000_0000);
    check("single_peak_index", 64'(o_peak_index), 5);

    // Most negative real and imaginary parts.
    drive_bin(32'h8000_8000, 7, 1'b1);
    tick();
    idle_bin();
    tick();
    tick();
    check("extreme_data", 64'(o_pwr_data), 64'h8000_0000);

    // Tie handling: powers 5, 9, 9, 2 -> earlier 9 wins.
    drive_bin(pack(1, 2), 0, 1'b0);
    tick();
    drive_bin(pack(3, 0), 1, 1'b0);
    tick();
    drive_bin(pack(0, -3), 2, 1'b0);
    tick();
    drive_bin(pack(1, -1), 3, 1'b1);
    tick();
    idle_bin();
    repeat (3) tick();
    check("tie_peak_valid", 64'(o_peak_valid), 1);
    check("tie_peak_index", 64'(o_peak_index), 1);
    check("tie_peak_value", 64'(o_peak_value), 9);

    // Backpressure: ten offered, eight fit.
    i_pwr_ready = 1'b0;
    repeat (4) tick();
    nacc = 0;
    for (int c = 0; c < 14; c++) begin
      drive_bin($urandom, 100 + nacc, nacc == 9);
      acc = o_bin_ready;
      tick();
      if (acc) nacc++;
    end
    check("bp_accepted", 64'(nacc), 8);
    check("bp_ready_low", 64'(o_bin_ready), 0);
    i_pwr_ready = 1'b1;
    for (int c = 0; c < 40 && nacc < 10; c++) begin
      drive_bin($urandom, 100 + nacc, nacc == 9);
      acc = o_bin_ready;
      tick();
      if (acc) nacc++;
    end
    idle_bin();
    check("bp_all_accepted", 64'(nacc), 10);
    repeat (12) tick();

    // Clear with three bins in flight.
    i_pwr_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive_bin($urandom, 200 + n, 1'b1);
      tick();
    end
    idle_bin();
    i_clear = 1'b1;
    #1;
    check("clr_bin_ready", 64'(o_bin_ready), 0);
    tick();
    i_clear = 1'b0;
    check("clr_pwr_valid", 64'(o_pwr_valid), 0);
    check("clr_peak_valid", 64'(o_peak_valid), 0);
    check("clr_peak_value", 64'(o_peak_value), 0);
    i_pwr_ready = 1'b1;
    repeat (5) tick();
    check("clr_no_stale", 64'(o_pwr_valid), 0);

    // Randomized traffic, including occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      mode = $urandom_range(0, 3);
      i_bin_valid = ($urandom_range(0, 99) < 70);
      case (mode)
        1:       i_bin_data = pack($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3);
        2:       i_bin_data = 32'h8000_8000;
        default: i_bin_data = $urandom;
      endcase
      i_bin_index = IdxW'($urandom);
      i_bin_last  = ($urandom_range(0, 4) == 0);
      i_pwr_ready = ($urandom_range(0, 99) < 60);
      i_clear     = ($urandom_range(0, 499) == 0);
      nrst        = !($urandom_range(0, 999) == 0);
      tick();
    end

    // Drain with a bounded wait.
    nrst = 1'b1;
    i_clear = 1'b0;
    idle_bin();
    i_pwr_ready = 1'b1;
    for (int c = 0; c < 60 && (exp_q.size() != 0 || pk_q.size() != 0); c++) tick();
    check("drain_pwr", 64'(exp_q.size()), 0);
    check("drain_peak", 64'(pk_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
